ps2_scancode_receiver: RTL

PS/2 device-to-host receiver that deserialises 11-bit keyboard frames from the raw PS2_CLK/PS2_DAT pins into 8-bit scan codes. It sits directly upstream of the scan-code display/decoder logic. It presents each valid byte on scan_code with a one-cycle scan_ready strobe. It also synchronises and filters the pins, checks parity and stop bit, and recovers from stalled frames by timeout.

---
 rtl/ps2_scancode_receiver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_receiver.sv
// rtl/ps2_scancode_receiver.sv - PS/2 device-to-host frame receiver producing 8-bit scan codes
// Synchronises and deglitches the PS/2 pins, deserialises 11-bit frames, and flags parity/stop/timeout errors.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] scan_code,
  output logic       scan_ready,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    FILT_LAST = 8'(FILTER_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_clk_q, filt_clk_d;
  logic [7:0]    filt_cnt_q, filt_cnt_d;
  logic          bit_evt;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          chk_q, chk_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    code_q, code_d;
  logic          ready_q, ready_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_DAT;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_cnt_d = '0;
    filt_clk_d = filt_clk_q;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end
  end

  assign bit_evt = filt_clk_q & ~filt_clk_d;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    chk_d     = chk_q;
    to_cnt_d  = to_cnt_q;
    code_d    = code_q;
    ready_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (state_q == S_IDLE) begin
      to_cnt_d = '0;
      if (bit_evt && !dat_s2_q) begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
      end
    end else if (bit_evt) begin
      to_cnt_d = '0;
      case (state_q)
        S_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          chk_d   = (^shift_q) ^ dat_s2_q;
          state_d = S_STOP;
        end
        default: begin
          // Stop-bit error outranks a parity error.
          if (!dat_s2_q) begin
            ferr_d = 1'b1;
          end else if (chk_q) begin
            code_d  = shift_q;
            ready_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end else if (to_cnt_q == TO_LAST) begin
      state_d   = S_IDLE;
      ferr_d    = 1'b1;
      bit_cnt_d = '0;
      to_cnt_d  = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      chk_q     <= 1'b0;
      to_cnt_q  <= '0;
      code_q    <= '0;
      ready_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      chk_q     <= chk_d;
      to_cnt_q  <= to_cnt_d;
      code_q    <= code_d;
      ready_q   <= ready_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign scan_code  = code_q;
  assign scan_ready = ready_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule
